// File: rtl/mcu_row_reader.sv
// Streams one completed 8-line MCU row out of a ping-pong EBR bank in MCU order, 8x8 raster within each MCU.
// Optional feature: define MCU_READER_OVERRUN_EN to flag frontbuffer_select changes that arrive mid-readout.
module mcu_row_reader #(
  parameter int width_pix = 320,
  parameter int num_ebr   = 5,
  parameter int ebr_size  = 512
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        frontbuffer_select,
  output logic                        rd_bank,
  output logic [$clog2(num_ebr)-1:0]  rd_block_select,
  output logic [$clog2(ebr_size)-1:0] rd_addr,
  output logic                        rd_en,
  input  logic [7:0]                  rd_data,
  output logic [7:0]                  out_pixval,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_first,
  output logic                        out_row_done,
  output logic                        overrun
);

  localparam int blk_w     = $clog2(num_ebr);
  localparam int addr_w    = $clog2(ebr_size);
  localparam int total_pix = 8 * width_pix;
  localparam int cnt_w     = $clog2(total_pix + 1);
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(total_pix - 1);
  localparam logic [blk_w-1:0] last_blk = blk_w'(num_ebr - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  state_t           state;
  logic             fb_q;
  logic             fb_prev;
  logic             rd_pend;
  logic [7:0]       skid [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       skid_cnt;
  logic [cnt_w-1:0] issued;
  logic [cnt_w-1:0] sent;
  logic             change;
  logic             pop;
  logic             can_issue;

  assign change = fb_q != fb_prev;
  assign pop    = out_valid && out_ready;
  // Reserve a slot for every read still in flight, so a stalled consumer can never overflow the skid buffer.
  assign can_issue  = (skid_cnt + {2'b00, rd_pend} + {2'b00, rd_en}) < 3'd4;
  assign out_valid  = skid_cnt != 3'd0;
  assign out_pixval = skid[rd_ptr];
  assign out_first  = out_valid && (sent[5:0] == 6'd0);

  always_ff @(posedge clock) begin
    if (nreset) begin
      for (int i = 0; i < 4; i++) skid[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      skid_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (rd_pend) begin
        skid[wr_ptr] <= rd_data;
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({rd_pend, pop})
        2'b10:   skid_cnt <= skid_cnt + 3'd1;
        2'b01:   skid_cnt <= skid_cnt - 3'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      state           <= IDLE;
      fb_q            <= frontbuffer_select;
      fb_prev         <= frontbuffer_select;
      rd_bank         <= 1'b0;
      rd_block_select <= '0;
      rd_addr         <= '0;
      rd_en           <= 1'b0;
      issued          <= '0;
      sent            <= '0;
      out_row_done    <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      fb_q         <= frontbuffer_select;
      fb_prev      <= fb_q;
      out_row_done <= 1'b0;
      rd_en        <= 1'b0;
      if (pop) sent <= sent + cnt_w'(1);
      case (state)
        IDLE: begin
          if (change) begin
            state           <= PRIME;
            rd_bank         <= ~fb_q;
            rd_block_select <= '0;
            rd_addr         <= '0;
            rd_en           <= 1'b1;
            issued          <= cnt_w'(1);
            sent            <= '0;
          end
        end
        PRIME, STREAM: begin
          state <= STREAM;
          if (can_issue) begin
            rd_en  <= 1'b1;
            issued <= issued + cnt_w'(1);
            // Low six address bits are {py, px}; the upper field only advances once every EBR has been visited.
            if (rd_addr[5:0] == 6'd63) begin
              if (rd_block_select == last_blk) begin
                rd_block_select <= '0;
                rd_addr         <= rd_addr + addr_w'(1);
              end else begin
                rd_block_select <= rd_block_select + blk_w'(1);
                rd_addr         <= {rd_addr[addr_w-1:6], 6'd0};
              end
            end else begin
              rd_addr <= rd_addr + addr_w'(1);
            end
            if (issued == last_idx) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && sent == last_idx) begin
            state        <= IDLE;
            out_row_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef MCU_READER_OVERRUN_EN
      if (change && state != IDLE) overrun <= 1'b1;
`else
      overrun <= 1'b0;
`endif
    end
  end

endmodule
